// File: rtl/ir_encoder.sv
// ----------------------------------------------------------------------------
// ir_encoder
//
// NEC-format infrared transmitter. A one-cycle request in IDLE captures a
// 32-bit word. The block then sends a complete frame: a leader mark and
// space, 32 pulse-distance bits starting with the LSB, a stop mark, and an
// idle-high gap. The gap gives the receiver time to return to idle.
//
// Ports
//   iCLK     in   1   system clock (50 MHz)
//   iRST_n   in   1   asynchronous active-low reset
//   iSEND    in   1   send request, only looked at in IDLE
//   iDATA    in  32   word to transmit, captured on the accepting cycle
//   oIRDA    out  1   demodulated line level (1 = idle/space, 0 = mark)
//   oIR_LED  out  1   carrier-modulated LED drive, 0 outside marks
//   oBUSY    out  1   high from the cycle after acceptance to the end of GAP
//   oDONE    out  1   one-cycle pulse on the last GAP cycle
// ----------------------------------------------------------------------------
module ir_encoder #(
    parameter int LEAD_LOW_DUR  = 450000,
    parameter int LEAD_HIGH_DUR = 225000,
    parameter int BIT_LOW_DUR   = 28000,
    parameter int ZERO_HIGH_DUR = 28000,
    parameter int ONE_HIGH_DUR  = 84500,
    parameter int STOP_LOW_DUR  = 28000,
    parameter int GAP_DUR       = 500000,
    parameter int CARRIER_HALF  = 658
) (
    input  logic        iCLK,
    input  logic        iRST_n,
    input  logic        iSEND,
    input  logic [31:0] iDATA,
    output logic        oIRDA,
    output logic        oIR_LED,
    output logic        oBUSY,
    output logic        oDONE
);

    localparam int CNT_W = 19;
    localparam int DIV_W = (CARRIER_HALF > 2) ? $clog2(CARRIER_HALF) : 1;

    localparam logic [CNT_W-1:0] LEAD_LOW_LAST  = CNT_W'(LEAD_LOW_DUR - 1);
    localparam logic [CNT_W-1:0] LEAD_HIGH_LAST = CNT_W'(LEAD_HIGH_DUR - 1);
    localparam logic [CNT_W-1:0] BIT_LOW_LAST   = CNT_W'(BIT_LOW_DUR - 1);
    localparam logic [CNT_W-1:0] ZERO_HIGH_LAST = CNT_W'(ZERO_HIGH_DUR - 1);
    localparam logic [CNT_W-1:0] ONE_HIGH_LAST  = CNT_W'(ONE_HIGH_DUR - 1);
    localparam logic [CNT_W-1:0] STOP_LOW_LAST  = CNT_W'(STOP_LOW_DUR - 1);
    localparam logic [CNT_W-1:0] GAP_LAST       = CNT_W'(GAP_DUR - 1);
    localparam logic [DIV_W-1:0] DIV_LAST       = DIV_W'(CARRIER_HALF - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_LOW,
        LEAD_HIGH,
        BIT_LOW,
        BIT_HIGH,
        STOP,
        GAP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [5:0]       bit_idx_reg, bit_idx_next;
    logic [31:0]      shift_reg, shift_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic             led_reg, led_next;
    logic             irda_reg, busy_reg, done_reg;
    logic [CNT_W-1:0] seg_last;
    logic             seg_end;
    logic             mark_next;

    // Last count of the current segment. The space after a data bit is long
    // or short depending on the bit now at the bottom of the shift register.
    always_comb begin
        seg_last = '0;
        case (state_reg)
            LEAD_LOW:  seg_last = LEAD_LOW_LAST;
            LEAD_HIGH: seg_last = LEAD_HIGH_LAST;
            BIT_LOW:   seg_last = BIT_LOW_LAST;
            BIT_HIGH:  seg_last = shift_reg[0] ? ONE_HIGH_LAST : ZERO_HIGH_LAST;
            STOP:      seg_last = STOP_LOW_LAST;
            GAP:       seg_last = GAP_LAST;
            default:   seg_last = '0;
        endcase
    end

    assign seg_end = (cnt_reg == seg_last);

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg + CNT_W'(1);
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        case (state_reg)
            IDLE: begin
                if (iSEND) begin
                    state_next   = LEAD_LOW;
                    shift_next   = iDATA;
                    bit_idx_next = '0;
                end
            end
            LEAD_LOW:  if (seg_end) state_next = LEAD_HIGH;
            LEAD_HIGH: if (seg_end) state_next = BIT_LOW;
            BIT_LOW:   if (seg_end) state_next = BIT_HIGH;
            BIT_HIGH: begin
                if (seg_end) begin
                    shift_next   = shift_reg >> 1;
                    bit_idx_next = bit_idx_reg + 6'd1;
                    state_next   = (bit_idx_reg == 6'd31) ? STOP : BIT_LOW;
                end
            end
            STOP:      if (seg_end) state_next = GAP;
            GAP:       if (seg_end) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
        // The counter in IDLE stays at 0, so a new frame starts from 0.
        if (state_next != state_reg || state_reg == IDLE) begin
            cnt_next = '0;
        end
    end

    assign mark_next = (state_next == LEAD_LOW) || (state_next == BIT_LOW) ||
                       (state_next == STOP);

    // Carrier divider. A mark always starts on the high half of the carrier.
    // A mark always follows a space, so a state change into a mark state
    // marks the start of a mark.
    always_comb begin
        div_next = '0;
        led_next = 1'b0;
        if (mark_next) begin
            if (state_next != state_reg) begin
                div_next = '0;
                led_next = 1'b1;
            end else if (div_reg == DIV_LAST) begin
                div_next = '0;
                led_next = ~led_reg;
            end else begin
                div_next = div_reg + DIV_W'(1);
                led_next = led_reg;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
            div_reg     <= '0;
            led_reg     <= 1'b0;
            irda_reg    <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
            div_reg     <= div_next;
            led_reg     <= led_next;
            // The outputs are registered from the next state. They therefore
            // line up exactly with the state they describe.
            irda_reg    <= ~mark_next;
            busy_reg    <= (state_next != IDLE);
            done_reg    <= (state_next == GAP) && (cnt_next == GAP_LAST);
        end
    end

    assign oIRDA   = irda_reg;
    assign oIR_LED = led_reg;
    assign oBUSY   = busy_reg;
    assign oDONE   = done_reg;

endmodule

// File: tb/tb_ir_encoder.sv
module tb_ir_encoder;

    // Durations are shortened so that a full frame lasts a few hundred cycles.
    localparam int LL = 20;
    localparam int LH = 10;
    localparam int BL = 3;
    localparam int ZH = 3;
    localparam int OH = 7;
    localparam int SL = 3;
    localparam int GP = 12;
    localparam int CH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        send = 1'b0;
    logic [31:0] data = '0;
    logic        irda, led, busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    bit cap_irda[$];
    bit cap_led[$];
    bit cap_busy[$];
    bit cap_done[$];
    bit exp_irda[$];
    bit exp_led[$];
    bit cap_timeout;
    bit post_busy;

    ir_encoder #(
        .LEAD_LOW_DUR(LL), .LEAD_HIGH_DUR(LH), .BIT_LOW_DUR(BL),
        .ZERO_HIGH_DUR(ZH), .ONE_HIGH_DUR(OH), .STOP_LOW_DUR(SL),
        .GAP_DUR(GP), .CARRIER_HALF(CH)
    ) dut (
        .iCLK(clk), .iRST_n(rst_n), .iSEND(send), .iDATA(data),
        .oIRDA(irda), .oIR_LED(led), .oBUSY(busy), .oDONE(done)
    );

    always #5 clk = ~clk;

    // ---------------- expected-waveform model ----------------
    task automatic push_seg(input bit mark, input int dur);
        for (int j = 0; j < dur; j++) begin
            exp_irda.push_back(!mark);
            exp_led.push_back(mark ? (((j / CH) % 2) == 0) : 1'b0);
        end
    endtask

    task automatic build_expected(input logic [31:0] d);
        exp_irda.delete();
        exp_led.delete();
        push_seg(1'b1, LL);
        push_seg(1'b0, LH);
        for (int i = 0; i < 32; i++) begin
            push_seg(1'b1, BL);
            push_seg(1'b0, d[i] ? OH : ZH);
        end
        push_seg(1'b1, SL);
        push_seg(1'b0, GP);
    endtask

    function automatic int frame_len(input logic [31:0] d);
        int n1 = $countones(d);
        return LL + LH + 32 * BL + n1 * OH + (32 - n1) * ZH + SL + GP;
    endfunction

    function automatic int count_diff(input bit a[$], input bit b[$]);
        int e = (a.size() > b.size()) ? a.size() - b.size() : b.size() - a.size();
        int m = (a.size() < b.size()) ? a.size() : b.size();
        for (int i = 0; i < m; i++) if (a[i] != b[i]) e++;
        return e;
    endfunction

    function automatic int count_val(input bit a[$], input bit v);
        int e = 0;
        foreach (a[i]) if (a[i] == v) e++;
        return e;
    endfunction

    // Pulse-distance decoding of the captured line, as a receiver does it.
    function automatic logic [31:0] decode_capture();
        int p = 0;
        int h;
        logic [31:0] w = '0;
        while (p < cap_irda.size() && cap_irda[p] == 1'b0) p++;
        while (p < cap_irda.size() && cap_irda[p] == 1'b1) p++;
        for (int i = 0; i < 32; i++) begin
            while (p < cap_irda.size() && cap_irda[p] == 1'b0) p++;
            h = 0;
            while (p < cap_irda.size() && cap_irda[p] == 1'b1) begin
                h++;
                p++;
            end
            w[i] = (h > (ZH + OH) / 2);
        end
        return w;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called #1 after an edge. Acceptance happens on the next edge (cycle 0).
    // The task returns in cycle 1 and then scrambles iDATA.
    task automatic start_send(input logic [31:0] d);
        send = 1'b1;
        data = d;
        @(posedge clk);
        #1;
        send = 1'b0;
        data = ~d;
    endtask

    // Records cycles 1..N, where oDONE is seen in cycle N. It then stops in
    // cycle N+1 and samples oBUSY there.
    task automatic capture(input int inject_at);
        cap_irda.delete();
        cap_led.delete();
        cap_busy.delete();
        cap_done.delete();
        cap_timeout = 1'b0;
        for (int k = 1; k <= 4000; k++) begin
            cap_irda.push_back(irda);
            cap_led.push_back(led);
            cap_busy.push_back(busy);
            cap_done.push_back(done);
            if (k == inject_at) begin
                send = 1'b1;
                data = 32'h12345678;
            end
            @(posedge clk);
            #1;
            send = 1'b0;
            if (cap_done[cap_done.size()-1]) begin
                post_busy = busy;
                return;
            end
        end
        cap_timeout = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int bad;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++; if (irda !== 1'b1) begin n_bad++; $display("FAIL reset_irda: got %b want 1", irda); end
        n_cmp++; if (led !== 1'b0) begin n_bad++; $display("FAIL reset_led: got %b want 0", led); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            #1;
            if (irda !== 1'b1 || led !== 1'b0 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        n_cmp++; if (bad !== 0) begin n_bad++; $display("FAIL idle_1000: got %0d bad cycles want 0", bad); end
        $display("test_reset: done");
    endtask

    task automatic test_frame();
        logic [31:0] d = 32'h5DA2FF00;
        int e;
        build_expected(d);
        start_send(d);
        capture(0);
        n_cmp++; if (cap_timeout !== 1'b0) begin n_bad++; $display("FAIL frame_timeout: got 1 want 0"); end
        n_cmp++; if (cap_irda.size() !== frame_len(d)) begin n_bad++; $display("FAIL frame_done_cycle: got %0d want %0d", cap_irda.size(), frame_len(d)); end
        n_cmp++; if (cap_irda[0] !== 1'b0 || cap_busy[0] !== 1'b1) begin n_bad++; $display("FAIL frame_cycle1: got irda=%b busy=%b want 0/1", cap_irda[0], cap_busy[0]); end
        n_cmp++; if (cap_irda[LL-1] !== 1'b0 || cap_irda[LL] !== 1'b1) begin n_bad++; $display("FAIL leader_rise: got %b%b want 01", cap_irda[LL-1], cap_irda[LL]); end
        e = count_diff(cap_irda, exp_irda);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL frame_irda_wave: got %0d wrong cycles want 0", e); end
        e = count_diff(cap_led, exp_led);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL frame_led_wave: got %0d wrong cycles want 0", e); end
        e = count_val(cap_busy, 1'b0);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL frame_busy: got %0d low cycles want 0", e); end
        e = count_val(cap_done, 1'b1);
        n_cmp++; if (e !== 1) begin n_bad++; $display("FAIL frame_done_pulses: got %0d want 1", e); end
        n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL frame_busy_fall: got %b want 0", post_busy); end
        n_cmp++; if (decode_capture() !== d) begin n_bad++; $display("FAIL frame_decode: got %h want %h", decode_capture(), d); end
        $display("test_frame: data=%h cycles=%0d", d, cap_irda.size());
    endtask

    task automatic test_leader_carrier();
        int e;
        // The capture is still from the 0x5DA2FF00 frame. Cycle k is at index k-1.
        n_cmp++; if (cap_led[0] !== 1'b1) begin n_bad++; $display("FAIL led_first_high: got %b want 1", cap_led[0]); end
        n_cmp++; if (cap_led[CH-1] !== 1'b1 || cap_led[CH] !== 1'b0) begin n_bad++; $display("FAIL led_half: got %b%b want 10", cap_led[CH-1], cap_led[CH]); end
        n_cmp++; if (cap_led[2*CH-1] !== 1'b0 || cap_led[2*CH] !== 1'b1) begin n_bad++; $display("FAIL led_period: got %b%b want 01", cap_led[2*CH-1], cap_led[2*CH]); end
        e = 0;
        for (int i = LL; i < LL + LH; i++) if (cap_led[i] !== 1'b0) e++;
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL led_lead_high: got %0d high cycles want 0", e); end
        $display("test_leader_carrier: done");
    endtask

    task automatic test_loopback(input logic [31:0] d);
        int e;
        build_expected(d);
        @(posedge clk);
        #1;
        start_send(d);
        capture(0);
        e = count_diff(cap_irda, exp_irda);
        n_cmp++; if (e !== 0 || cap_timeout !== 1'b0) begin n_bad++; $display("FAIL loop_wave %h: got %0d wrong cycles timeout=%b want 0", d, e, cap_timeout); end
        n_cmp++; if (decode_capture() !== d) begin n_bad++; $display("FAIL loop_decode: got %h want %h", decode_capture(), d); end
        $display("test_loopback: data=%h decoded=%h", d, decode_capture());
    endtask

    task automatic test_ignore_midframe();
        logic [31:0] d = 32'h5DA2FF00;
        int e;
        build_expected(d);
        @(posedge clk);
        #1;
        start_send(d);
        capture(150);
        e = count_diff(cap_irda, exp_irda);
        n_cmp++; if (e !== 0 || cap_timeout !== 1'b0) begin n_bad++; $display("FAIL ignore_wave: got %0d wrong cycles want 0", e); end
        n_cmp++; if (cap_irda.size() !== frame_len(d)) begin n_bad++; $display("FAIL ignore_len: got %0d want %0d", cap_irda.size(), frame_len(d)); end
        // Still idle afterwards: the ignored request was not queued.
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || irda !== 1'b1) begin n_bad++; $display("FAIL ignore_noqueue: got busy=%b irda=%b want 0/1", busy, irda); end
        $display("test_ignore_midframe: done");
    endtask

    task automatic test_back_to_back();
        logic [31:0] d1 = 32'h0000FFFF;
        logic [31:0] d2 = 32'hA5A50F0F;
        int e;
        @(posedge clk);
        #1;
        start_send(d1);
        capture(0);
        n_cmp++; if (post_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_busy_fall: got %b want 0", post_busy); end
        // Request in the first cycle with oBUSY low.
        build_expected(d2);
        start_send(d2);
        n_cmp++; if (irda !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept: got irda=%b busy=%b want 0/1", irda, busy); end
        capture(0);
        e = count_diff(cap_irda, exp_irda);
        n_cmp++; if (e !== 0 || cap_timeout !== 1'b0) begin n_bad++; $display("FAIL b2b_wave: got %0d wrong cycles want 0", e); end
        n_cmp++; if (decode_capture() !== d2) begin n_bad++; $display("FAIL b2b_decode: got %h want %h", decode_capture(), d2); end
        $display("test_back_to_back: %h then %h", d1, d2);
    endtask

    task automatic test_reset_midframe();
        logic [31:0] d = 32'h5DA2FF00;
        logic [31:0] d2 = 32'h00FF00FF;
        int t = LL + LH;
        int e;
        // Second cycle of bit 10's space. Bit 10 is a 1, so the space is long.
        for (int i = 0; i < 10; i++) t += BL + (d[i] ? OH : ZH);
        t += BL + 2;
        @(posedge clk);
        #1;
        start_send(d);
        repeat (t - 1) @(posedge clk);
        #1;
        n_cmp++; if (irda !== 1'b1 || busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_pre: got irda=%b busy=%b want 1/1", irda, busy); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (irda !== 1'b1 || led !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rstmid_async: got %b%b%b%b want 1000", irda, led, busy, done); end
        @(posedge clk);
        #1;
        n_cmp++; if (irda !== 1'b1 || led !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL rstmid_edge: got %b%b%b%b want 1000", irda, led, busy, done); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (busy !== 1'b0 || irda !== 1'b1) begin n_bad++; $display("FAIL rstmid_idle: got busy=%b irda=%b want 0/1", busy, irda); end
        build_expected(d2);
        start_send(d2);
        capture(0);
        e = count_diff(cap_irda, exp_irda);
        n_cmp++; if (e !== 0 || cap_timeout !== 1'b0) begin n_bad++; $display("FAIL rstmid_wave: got %0d wrong cycles want 0", e); end
        e = count_diff(cap_led, exp_led);
        n_cmp++; if (e !== 0) begin n_bad++; $display("FAIL rstmid_led: got %0d wrong cycles want 0", e); end
        n_cmp++; if (decode_capture() !== d2) begin n_bad++; $display("FAIL rstmid_decode: got %h want %h", decode_capture(), d2); end
        $display("test_reset_midframe: reset at cycle %0d, refill %h", t, d2);
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_frame();
        test_leader_carrier();
        test_loopback(32'hFF000000);
        test_loopback(32'h00FFFFFF);
        test_ignore_midframe();
        test_back_to_back();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
